// File: rtl/lightsout_pkg.sv
// Shared scancode constants, sequencer state type and small helpers for the
// PS/2 key sequencer.
package lightsout_pkg;

    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_UP     = 8'h75;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_DOWN   = 8'h72;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_ENTER  = 8'h5A;
    localparam logic [7:0] SC_QUIT   = 8'h15;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;

    typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} seq_state_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

    // Keyboard housekeeping bytes that carry no key information.
    function automatic logic is_filler(input logic [7:0] b);
        return (b == SC_BAT) || (b == SC_ACK) || (b == SC_RESEND) ||
               (b == 8'h00) || (b == 8'hFF);
    endfunction

endpackage

// File: rtl/lightsout_cycle_timer.sv
// Up-counter with clear and enable; o_expire is high while enabled at the
// terminal count (i_limit_m1). The count saturates there until cleared.
module lightsout_cycle_timer #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         i_clr,
    input  logic         i_en,
    input  logic [W-1:0] i_limit_m1,
    output logic         o_expire
);

    logic [W-1:0] r_cnt;

    assign o_expire = i_en && (r_cnt == i_limit_m1);

    always_ff @(posedge clk) begin
        if (reset || i_clr)
            r_cnt <= '0;
        else if (i_en && (r_cnt != i_limit_m1))
            r_cnt <= r_cnt + 1'b1;
    end

endmodule

// File: rtl/ps2_key_sequencer.sv
// PS/2 scancode parser: one key_en per key press, typematic suppression and
// prefix timeout. Define LIGHTSOUT_AUTOREPEAT_EN for timed auto-repeat.
module ps2_key_sequencer
    import lightsout_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 1250000,
    parameter int REPEAT_DELAY   = 25000000,
    parameter int REPEAT_PERIOD  = 5000000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [7:0] scan_data,
    input  logic       scan_valid,
    output logic [7:0] key_code,
    output logic       key_ext,
    output logic       key_en,
    output logic       key_held,
    output logic       timeout
);

    localparam int CW = $clog2(max3(TIMEOUT_CYCLES, REPEAT_DELAY, REPEAT_PERIOD)) + 1;
    localparam logic [CW-1:0] TO_LIM = CW'(TIMEOUT_CYCLES - 1);

    seq_state_t r_state, w_nstate;
    logic [7:0] r_key_code;
    logic       r_key_ext, r_key_en, r_timeout;
    logic [8:0] r_held;
    logic       r_held_vld;
    logic       w_make, w_brk, w_ext, w_match, w_to_exp, w_rep_fire;
    logic [8:0] w_key;

    assign key_code = r_key_code;
    assign key_ext  = r_key_ext;
    assign key_en   = r_key_en;
    assign key_held = r_held_vld;
    assign timeout  = r_timeout;

    lightsout_cycle_timer #(.W(CW)) u_timeout (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (scan_valid || (r_state == IDLE)),
        .i_en       (r_state != IDLE),
        .i_limit_m1 (TO_LIM),
        .o_expire   (w_to_exp)
    );

`ifdef LIGHTSOUT_AUTOREPEAT_EN
    localparam logic [CW-1:0] RD_LIM = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] RP_LIM = CW'(REPEAT_PERIOD - 1);
    logic r_rep_phase, w_rep_exp;

    // Restarts on every byte and after each repeat; phase picks delay vs period.
    lightsout_cycle_timer #(.W(CW)) u_repeat (
        .clk        (clk),
        .reset      (reset),
        .i_clr      (scan_valid || !r_held_vld || w_rep_exp),
        .i_en       (r_held_vld),
        .i_limit_m1 (r_rep_phase ? RP_LIM : RD_LIM),
        .o_expire   (w_rep_exp)
    );

    always_ff @(posedge clk) begin
        if (reset || scan_valid || !r_held_vld)
            r_rep_phase <= 1'b0;
        else if (w_rep_exp)
            r_rep_phase <= 1'b1;
    end

    assign w_rep_fire = w_rep_exp && !scan_valid;
`else
    assign w_rep_fire = 1'b0;
`endif

    always_comb begin
        w_nstate = r_state;
        w_make   = 1'b0;
        w_brk    = 1'b0;
        w_ext    = 1'b0;
        if (scan_valid) begin
            case (r_state)
                IDLE: begin
                    if (scan_data == SC_EXT)
                        w_nstate = EXT;
                    else if (scan_data == SC_BREAK)
                        w_nstate = BRK;
                    else if (!is_filler(scan_data))
                        w_make = 1'b1;
                end
                EXT: begin
                    if (scan_data == SC_BREAK) begin
                        w_nstate = EXT_BRK;
                    end else if (scan_data != SC_EXT) begin
                        w_make   = 1'b1;
                        w_ext    = 1'b1;
                        w_nstate = IDLE;
                    end
                end
                BRK: begin
                    w_brk    = 1'b1;
                    w_nstate = IDLE;
                end
                default: begin
                    w_brk    = 1'b1;
                    w_ext    = 1'b1;
                    w_nstate = IDLE;
                end
            endcase
        end else if (w_to_exp) begin
            w_nstate = IDLE;
        end
    end

    assign w_key   = {w_ext, scan_data};
    assign w_match = r_held_vld && (r_held == w_key);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= IDLE;
            r_key_code <= 8'h00;
            r_key_ext  <= 1'b0;
            r_key_en   <= 1'b0;
            r_timeout  <= 1'b0;
            r_held     <= 9'h000;
            r_held_vld <= 1'b0;
        end else begin
            r_state   <= w_nstate;
            r_key_en  <= 1'b0;
            r_timeout <= w_to_exp && !scan_valid;
            if (w_make && !w_match) begin
                r_key_code <= scan_data;
                r_key_ext  <= w_ext;
                r_key_en   <= 1'b1;
                r_held     <= w_key;
                r_held_vld <= 1'b1;
            end else if (w_brk && w_match) begin
                r_held_vld <= 1'b0;
            end else if (w_rep_fire) begin
                r_key_code <= r_held[7:0];
                r_key_ext  <= r_held[8];
                r_key_en   <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_ps2_key_sequencer.sv
// Self-checking bench for ps2_key_sequencer: directed scenarios plus a
// randomized byte stream checked against a behavioural key model.
module tb_ps2_key_sequencer;

    localparam int T_TO  = 16;
    localparam int T_RD  = 20;
    localparam int T_RP  = 5;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [7:0] scan_data = 8'h00;
    logic       scan_valid = 1'b0;
    logic [7:0] key_code;
    logic       key_ext, key_en, key_held, timeout;

    int n_chk  = 0;
    int n_fail = 0;
    int ev_cnt = 0;
    int to_cnt = 0;

    // Behavioural model: pending prefixes and the held key.
    bit         m_ext, m_brk, m_hv;
    logic [8:0] m_held;

    ps2_key_sequencer #(
        .TIMEOUT_CYCLES (T_TO),
        .REPEAT_DELAY   (T_RD),
        .REPEAT_PERIOD  (T_RP)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .scan_data  (scan_data),
        .scan_valid (scan_valid),
        .key_code   (key_code),
        .key_ext    (key_ext),
        .key_en     (key_en),
        .key_held   (key_held),
        .timeout    (timeout)
    );

    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (key_en)  ev_cnt <= ev_cnt + 1;
        if (timeout) to_cnt <= to_cnt + 1;
    end

    task automatic model_clear();
        m_ext = 0; m_brk = 0; m_hv = 0; m_held = '0;
    endtask

    task automatic model_byte(input logic [7:0] b, output bit ev, output bit ex);
        logic [8:0] k;
        ev = 0; ex = 0;
        k = {m_ext, b};
        if (m_brk) begin
            if (m_hv && m_held == k) m_hv = 0;
            m_brk = 0; m_ext = 0;
        end else if (b == 8'hF0) begin
            m_brk = 1;
        end else if (b == 8'hE0) begin
            m_ext = 1;
        end else if (!m_ext && (b == 8'hAA || b == 8'hFA || b == 8'hFE || b == 8'h00 || b == 8'hFF)) begin
            ev = 0;
        end else begin
            ex = m_ext;
            if (!(m_hv && m_held == k)) begin
                ev = 1; m_held = k; m_hv = 1;
            end
            m_ext = 0;
        end
    endtask

    // Strobe one byte; returns at the mid-point of the following cycle.
    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        scan_data = b; scan_valid = 1'b1;
        @(negedge clk);
        scan_valid = 1'b0;
    endtask

    task automatic do_reset();
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
    endtask

    task automatic test_reset();
        scan_valid = 1'b0;
        reset = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++; if ({key_code, key_ext, key_en, key_held, timeout} !== 12'h000) begin
            n_fail++; $display("FAIL reset_outputs: got code=%h ext=%b en=%b held=%b to=%b, want all 0",
                               key_code, key_ext, key_en, key_held, timeout);
        end
        reset = 1'b0;
        model_clear();
        @(negedge clk);
        n_chk++; if (key_en !== 1'b0 || timeout !== 1'b0) begin
            n_fail++; $display("FAIL reset_release: en=%b to=%b, want 0 0", key_en, timeout);
        end
    endtask

    task automatic test_make();
        do_reset();
        send_byte(8'h75);
        n_chk++; if (key_en !== 1'b1 || key_code !== 8'h75 || key_ext !== 1'b0 || key_held !== 1'b1) begin
            n_fail++; $display("FAIL make_event: en=%b code=%h ext=%b held=%b, want 1 75 0 1",
                               key_en, key_code, key_ext, key_held);
        end
        @(negedge clk);
        n_chk++; if (key_en !== 1'b0 || key_code !== 8'h75) begin
            n_fail++; $display("FAIL make_one_cycle: en=%b code=%h, want 0 75", key_en, key_code);
        end
    endtask

    task automatic test_typematic();
        int base;
        do_reset();
        base = ev_cnt;
        send_byte(8'h75); send_byte(8'h75); send_byte(8'h75);
        send_byte(8'hF0);
        n_chk++; if (key_held !== 1'b1) begin
            n_fail++; $display("FAIL typematic_held_before_break: held=%b, want 1", key_held);
        end
        send_byte(8'h75);
        n_chk++; if (key_held !== 1'b0 || key_en !== 1'b0) begin
            n_fail++; $display("FAIL typematic_release: held=%b en=%b, want 0 0", key_held, key_en);
        end
        @(negedge clk);
        n_chk++; if (ev_cnt - base !== 1) begin
            n_fail++; $display("FAIL typematic_count: got %0d events, want 1", ev_cnt - base);
        end
    endtask

    task automatic test_extended();
        int base;
        do_reset();
        base = ev_cnt;
        send_byte(8'hE0);
        n_chk++; if (key_en !== 1'b0) begin
            n_fail++; $display("FAIL ext_prefix_no_event: en=%b, want 0", key_en);
        end
        send_byte(8'h74);
        n_chk++; if (key_en !== 1'b1 || key_code !== 8'h74 || key_ext !== 1'b1 || key_held !== 1'b1) begin
            n_fail++; $display("FAIL ext_make: en=%b code=%h ext=%b held=%b, want 1 74 1 1",
                               key_en, key_code, key_ext, key_held);
        end
        send_byte(8'h74);
        n_chk++; if (key_en !== 1'b1 || key_ext !== 1'b0 || key_held !== 1'b1) begin
            n_fail++; $display("FAIL plain_vs_ext_distinct: en=%b ext=%b held=%b, want 1 0 1",
                               key_en, key_ext, key_held);
        end
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        n_chk++; if (key_held !== 1'b1 || key_en !== 1'b0) begin
            n_fail++; $display("FAIL ext_break_nonmatching: held=%b en=%b, want 1 0", key_held, key_en);
        end
        send_byte(8'hE0); send_byte(8'h74);
        send_byte(8'hE0); send_byte(8'hF0); send_byte(8'h74);
        n_chk++; if (key_held !== 1'b0 || key_en !== 1'b0) begin
            n_fail++; $display("FAIL ext_break_release: held=%b en=%b, want 0 0", key_held, key_en);
        end
        @(negedge clk);
        n_chk++; if (ev_cnt - base !== 3) begin
            n_fail++; $display("FAIL ext_count: got %0d events, want 3", ev_cnt - base);
        end
    endtask

    task automatic test_timeout();
        int hits, first;
        do_reset();
        send_byte(8'hF0);
        hits = 0; first = -1;
        for (int i = 1; i <= 40; i++) begin
            @(negedge clk);
            if (timeout === 1'b1) begin
                hits++;
                if (first < 0) first = i;
            end
        end
        n_chk++; if (hits !== 1 || first !== T_TO) begin
            n_fail++; $display("FAIL timeout_pulse: got %0d pulses first at +%0d, want 1 at +%0d",
                               hits, first, T_TO);
        end
        send_byte(8'h5A);
        n_chk++; if (key_en !== 1'b1 || key_code !== 8'h5A || key_ext !== 1'b0) begin
            n_fail++; $display("FAIL timeout_recover: en=%b code=%h ext=%b, want 1 5a 0",
                               key_en, key_code, key_ext);
        end
    endtask

    task automatic test_ignore_reset();
        int base;
        do_reset();
        base = ev_cnt;
        send_byte(8'hAA); send_byte(8'hFA); send_byte(8'hE0);
        @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        model_clear();
        n_chk++; if (ev_cnt - base !== 0 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL ignore_no_events: got %0d events held=%b, want 0 0",
                               ev_cnt - base, key_held);
        end
        send_byte(8'h6B);
        n_chk++; if (key_en !== 1'b1 || key_code !== 8'h6B || key_ext !== 1'b0) begin
            n_fail++; $display("FAIL reset_drops_prefix: en=%b code=%h ext=%b, want 1 6b 0",
                               key_en, key_code, key_ext);
        end
    endtask

    task automatic test_hold();
        int bad;
        bit want;
        do_reset();
        send_byte(8'h72);
        n_chk++; if (key_en !== 1'b1 || key_code !== 8'h72) begin
            n_fail++; $display("FAIL hold_first: en=%b code=%h, want 1 72", key_en, key_code);
        end
        bad = 0;
        for (int i = 2; i <= 40; i++) begin
            @(negedge clk);
`ifdef LIGHTSOUT_AUTOREPEAT_EN
            want = (i >= T_RD + 1) && ((i - T_RD - 1) % T_RP == 0);
`else
            want = 1'b0;
`endif
            if (key_en !== want || (want && key_code !== 8'h72)) begin
                bad++;
                if (bad == 1) $display("FAIL hold_repeat: at +%0d en=%b code=%h, want en=%b",
                                       i, key_en, key_code, want);
            end
        end
        n_chk++; if (bad != 0) begin
            n_fail++; $display("FAIL hold_repeat_total: %0d bad cycles, want 0", bad);
        end
        send_byte(8'hF0); send_byte(8'h72);
        bad = 0;
        for (int i = 0; i < 30; i++) begin
            @(negedge clk);
            if (key_en !== 1'b0) bad++;
        end
        n_chk++; if (bad != 0 || key_held !== 1'b0) begin
            n_fail++; $display("FAIL hold_stop: %0d events after release held=%b, want 0 0", bad, key_held);
        end
    endtask

    task automatic test_random();
        logic [7:0] pool [11];
        logic [7:0] b, last_code;
        int base_ev, base_to, exp_ev, exp_to, k, kmax, bad;
        bit ev, ex;
        pool = '{8'h75, 8'h6B, 8'h72, 8'h74, 8'h5A, 8'h15, 8'hE0, 8'hF0, 8'hAA, 8'hFA, 8'h00};
`ifdef LIGHTSOUT_AUTOREPEAT_EN
        kmax = T_TO - 2;
`else
        kmax = T_TO + 2;
`endif
        do_reset();
        base_ev = ev_cnt; base_to = to_cnt;
        exp_ev = 0; exp_to = 0; bad = 0; last_code = 8'h00;
        for (int n = 0; n < 400; n++) begin
            b = pool[$urandom_range(0, 10)];
            k = ($urandom_range(0, 3) == 0) ? $urandom_range(0, kmax) : 0;
            repeat (k) @(negedge clk);
            // A prefix survives only if the next byte lands no later than its expiry cycle.
            if ((m_ext || m_brk) && k > T_TO - 2) begin
                m_ext = 0; m_brk = 0; exp_to++;
            end
            model_byte(b, ev, ex);
            send_byte(b);
            if (ev) begin
                exp_ev++; last_code = b;
                if (key_en !== 1'b1 || key_code !== b || key_ext !== ex) bad++;
            end else if (key_en !== 1'b0 || key_code !== last_code) begin
                bad++;
            end
            if (key_held !== m_hv) bad++;
            if (bad == 1 && n_fail >= 0) begin
                $display("FAIL random_step: byte %h gap %0d en=%b code=%h ext=%b held=%b, want ev=%b code=%h ext=%b held=%b",
                         b, k, key_en, key_code, key_ext, key_held, ev, ev ? b : last_code, ex, m_hv);
                bad++;
            end
        end
        n_chk++; if (bad != 0) begin
            n_fail++; $display("FAIL random_stream: %0d step errors, want 0", bad);
        end
        @(negedge clk);
        n_chk++; if (ev_cnt - base_ev !== exp_ev) begin
            n_fail++; $display("FAIL random_event_count: got %0d, want %0d", ev_cnt - base_ev, exp_ev);
        end
        if (m_ext || m_brk) exp_to++;
        repeat (T_TO + 4) @(negedge clk);
        n_chk++; if (to_cnt - base_to !== exp_to) begin
            n_fail++; $display("FAIL random_timeout_count: got %0d, want %0d", to_cnt - base_to, exp_to);
        end
    endtask

    initial begin
        test_reset();
        test_make();
        test_typematic();
        test_extended();
        test_timeout();
        test_ignore_reset();
        test_hold();
        test_random();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
